pc_fetch_unit: RTL
==================

# pc_fetch_unit

Parametrised program-counter and fetch front end: owns the PC, issues in-order instruction-fetch requests to instruction memory under a valid/ready handshake, and buffers returned instructions with their PCs for the decode stage. Jumps and debug resets flush the buffer and discard responses still in flight, so decode never sees a wrong-path instruction. Sits between the execute/control logic (jump, hold) and the instruction bus.

## Interface
- XLEN, 32, address/PC width in bits
- ILEN, 32, instruction word width in bits
- RESET_PC, 0, PC value after rst or jtag_reset_flag_i
- DEPTH, 4, instruction buffer entries; also the cap on outstanding plus buffered fetches (power of two, ≥2)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- jump_flag_i  in  1  redirect PC to jump_addr_i and flush
- jump_addr_i  in  XLEN  jump target, word-aligned
- hold_flag_i  in  1  stall: issue no new fetch requests
- jtag_reset_flag_i  in  1  debug reset: redirect to RESET_PC and flush
- req_valid_o  out  1  fetch request valid
- req_addr_o  out  XLEN  fetch address (current PC)
- req_ready_i  in  1  memory accepts request
- rsp_valid_i  in  1  instruction response, in request order, ≥1 cycle after acceptance, no backpressure
- rsp_data_i  in  ILEN  fetched instruction
- inst_valid_o  out  1  buffer head holds a filled instruction
- inst_o  out  ILEN  head instruction
- inst_pc_o  out  XLEN  PC of head instruction
- inst_ready_i  in  1  decode consumes head

## Operation
- Priority per cycle: rst > jtag_reset_flag_i > jump_flag_i > hold_flag_i > normal issue.
- State: pc, buffer of DEPTH entries {pc, data, filled}, alloc/fill/read pointers, drop_cnt (width clog2(DEPTH+1)).
- credits = DEPTH − occupied_entries − drop_cnt.
- req_valid_o = !hold_flag_i && !jump_flag_i && !jtag_reset_flag_i && credits > 0; req_addr_o = pc.
- Request accepted (req_valid_o && req_ready_i): allocate entry with pc, pc ← pc + ILEN/8 (wraps modulo 2^XLEN).
- Response with drop_cnt > 0: discarded, drop_cnt − 1. Otherwise: written into the oldest unfilled entry, which becomes filled.
- inst_valid_o = head entry filled; consume on inst_valid_o && inst_ready_i, freeing the entry.
- Flush (jump or jtag reset): pc ← target (jump_addr_i or RESET_PC); all entries freed; drop_cnt ← drop_cnt + unfilled_entries − rsp_valid_i; consumption and any response that cycle are ignored, except for the drop_cnt accounting above.
- hold_flag_i blocks issue only; responses and consumption continue.

## Timing
- Reset values: pc = RESET_PC, buffer empty, drop_cnt = 0; req_valid_o = 1 on first post-reset cycle unless held; req_addr_o = RESET_PC; inst_valid_o = 0; inst_o and inst_pc_o = 0 until first fill.
- Issue-to-issue: one request per cycle at full throughput.
- Response-to-decode: inst_valid_o rises the cycle after rsp_valid_i (registered fill).
- Flush: req_valid_o low in the flush cycle; the next cycle presents the target address, with inst_valid_o = 0.
- Full: credits = 0 holds req_valid_o low. A consumption frees a credit the following cycle.
- Flush while drop_cnt > 0: the counts accumulate; drop_cnt never exceeds DEPTH.
- rst mid-operation: immediate return to the reset state, drop_cnt = 0. The bench guarantees memory is also reset.

## Structure
- Shared package: XLEN, ILEN, RESET_PC defaults; instruction-byte-step constant; buffer entry struct {pc, data, filled}.
- One sub-module: pc_fetch_buf holds the entry array, the three pointers and the occupancy count. pc_fetch_unit holds pc, drop_cnt, credit and flush logic.

## Test plan
- Reset then free-running memory, rsp 1 cycle later, inst_ready_i=1 → requests at 0x0, 0x4, 0x8… each cycle; inst_pc_o/inst_o in the same order, 2 cycles after each request.
- inst_ready_i=0, DEPTH=4 → exactly 4 requests accepted (0x0–0xC), then req_valid_o low; raise inst_ready_i for 1 cycle → one request at 0x10.
- Jump to 0x100 with 3 unfilled fetches → next request at 0x100; the 3 late responses are dropped; first inst_pc_o = 0x100.
- Jump in the same cycle as rsp_valid_i with 2 unfilled → drop_cnt = 1; only one later response is dropped.
- hold_flag_i high for 5 cycles with 2 outstanding → no requests; both instructions are still delivered; issue resumes at next PC.
- jtag_reset_flag_i mid-stream, RESET_PC=0x8000_0000 → flush; next request at 0x8000_0000; no stale inst_valid_o.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the program-counter / fetch front end.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Contents: default widths and reset PC, instruction byte step helper,
//           default-width buffer entry record {pc, data, filled}.
package pc_fetch_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned ILEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // One buffered fetch: where it came from, what came back, and whether
  // the memory has answered yet.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] data;
    logic                filled;
  } fetch_entry_t;

  // Bytes the PC advances per sequential fetch.
  function automatic int unsigned inst_step(input int unsigned ilen);
    return ilen / 8;
  endfunction

endpackage

// File: rtl/pc_fetch_buf.sv
// In-order fetch buffer: entries are allocated at request time and filled
// when the matching response returns, so decode sees program order.
// Latency: a fill is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller must not allocate when full.
// Ports: clk/rst; flush frees every entry; alloc/alloc_pc reserve the next
//        slot; fill/fill_data complete the oldest unfilled slot; pop retires
//        the head; head_* describe the head; occupied/unfilled are counts.
module pc_fetch_buf
  import pc_fetch_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned ILEN  = ILEN_DEF,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [ILEN-1:0] fill_data,
  input  logic            pop,
  output logic            head_filled,
  output logic [XLEN-1:0] head_pc,
  output logic [ILEN-1:0] head_data,
  output logic [CW-1:0]   occupied,
  output logic [CW-1:0]   unfilled
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] data;
    logic            filled;
  } entry_t;

  entry_t        ents [DEPTH];

  // Pointers carry one extra wrap bit (DEPTH is a power of two), so plain
  // subtraction yields the allocated and outstanding counts.
  logic [CW-1:0] alloc_ptr;
  logic [CW-1:0] fill_ptr;
  logic [CW-1:0] rd_ptr;

  logic          alloc_ok;
  logic          fill_ok;
  logic          pop_ok;
  entry_t        head;

  assign occupied    = alloc_ptr - rd_ptr;
  assign unfilled    = alloc_ptr - fill_ptr;
  assign head        = ents[rd_ptr[PW-1:0]];
  assign head_filled = head.filled;
  assign head_pc     = head.pc;
  assign head_data   = head.data;

  // Guards keep the pointers consistent even if a caller misbehaves
  // (allocate when full, response with nothing outstanding).
  assign alloc_ok = alloc && (occupied != FULL);
  assign fill_ok  = fill && (unfilled != '0);
  assign pop_ok   = pop && head.filled;

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ents[i] <= '0;
      end
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ents[i].filled <= 1'b0;
      end
    end else begin
      // Alloc, fill and pop always target distinct slots: a free slot,
      // the oldest allocated-but-empty slot, and the filled head.
      if (alloc_ok) begin
        ents[alloc_ptr[PW-1:0]].pc     <= alloc_pc;
        ents[alloc_ptr[PW-1:0]].filled <= 1'b0;
        alloc_ptr                      <= alloc_ptr + 1'b1;
      end
      if (fill_ok) begin
        ents[fill_ptr[PW-1:0]].data   <= fill_data;
        ents[fill_ptr[PW-1:0]].filled <= 1'b1;
        fill_ptr                      <= fill_ptr + 1'b1;
      end
      if (pop_ok) begin
        ents[rd_ptr[PW-1:0]].filled <= 1'b0;
        rd_ptr                      <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC owner and fetch front end: issues in-order fetches, buffers returned
// instructions with their PCs, and discards wrong-path responses after a flush.
// Latency: request-to-decode 2 cycles minimum (memory 1 cycle + registered fill).
// Backpressure: issue stops when buffered + in-flight + to-be-dropped reaches
//               DEPTH; decode stalls via inst_ready_i; responses never stall.
// Ports: clk/rst; jump_flag_i/jump_addr_i redirect; hold_flag_i stalls issue;
//        jtag_reset_flag_i redirects to RESET_PC; req_* fetch request;
//        rsp_* fetch response; inst_* head instruction towards decode.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     ILEN     = ILEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_flag_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            hold_flag_i,
  input  logic            jtag_reset_flag_i,
  output logic            req_valid_o,
  output logic [XLEN-1:0] req_addr_o,
  input  logic            req_ready_i,
  input  logic            rsp_valid_i,
  input  logic [ILEN-1:0] rsp_data_i,
  output logic            inst_valid_o,
  output logic [ILEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i
);

  localparam int unsigned     CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(inst_step(ILEN));

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   drop_q;
  logic [CW-1:0]   drop_flush;
  logic [CW-1:0]   occupied;
  logic [CW-1:0]   unfilled;
  logic [CW-1:0]   used;

  logic            flush;
  logic            has_credit;
  logic            accept;
  logic            fill;
  logic            pop;

  assign flush = jtag_reset_flag_i || jump_flag_i;

  // occupied + drop_q never exceeds DEPTH, so the sum fits in CW bits.
  assign used       = occupied + drop_q;
  assign has_credit = (used < FULL);

  assign req_valid_o = !hold_flag_i && !flush && has_credit;
  assign req_addr_o  = pc_q;
  assign accept      = req_valid_o && req_ready_i;

  // Responses owed to a flushed path are swallowed before any reach the
  // buffer; during a flush nothing new enters or leaves.
  assign fill = rsp_valid_i && (drop_q == '0) && !flush;
  assign pop  = inst_valid_o && inst_ready_i && !flush;

  // Every fetch still unanswered at a flush becomes a response to drop,
  // less the one arriving this very cycle (it is consumed here either
  // as a drop or as a fill of a freed entry).
  always_comb begin
    drop_flush = drop_q + unfilled;
    if (rsp_valid_i && (drop_flush != '0)) begin
      drop_flush = drop_flush - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      if (jtag_reset_flag_i) begin
        pc_q <= RESET_PC;
      end else if (jump_flag_i) begin
        pc_q <= jump_addr_i;
      end else if (accept) begin
        pc_q <= pc_q + STEP;
      end

      if (flush) begin
        drop_q <= drop_flush;
      end else if (rsp_valid_i && (drop_q != '0)) begin
        drop_q <= drop_q - 1'b1;
      end
    end
  end

  pc_fetch_buf #(
    .XLEN  (XLEN),
    .ILEN  (ILEN),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .alloc       (accept),
    .alloc_pc    (pc_q),
    .fill        (fill),
    .fill_data   (rsp_data_i),
    .pop         (pop),
    .head_filled (inst_valid_o),
    .head_pc     (inst_pc_o),
    .head_data   (inst_o),
    .occupied    (occupied),
    .unfilled    (unfilled)
  );

endmodule
